// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode/issue pipeline register between register-file read and the ALU.
//   Captures an instruction, its PC and its rs1/rs2 read data, builds the
//   immediate for the opcode class and registers the ALU operand pair with
//   the control fields that the execute stage needs. There is one output
//   slot, a valid/ready handshake on each side, a flush input, and optional
//   forwarding from writeback.
//
//   Optional feature macro: ALU_ISSUE_FWD_EN
//     defined   : writeback data (fwd_*) overrides rs1/rs2 read data at capture
//     undefined : fwd_* ports are present but ignored
//
// Ports
//   clk, rst                synchronous active-high reset
//   in_valid / in_ready     upstream handshake (in_ready is combinational)
//   in_inst, in_pc          instruction word and its PC
//   rs1_data, rs2_data      register-file read data for inst[19:15] / inst[24:20]
//   flush                   kill held and incoming instruction
//   fwd_we, fwd_rd, fwd_data  writeback port used for forwarding
//   out_valid / out_ready   downstream handshake
//   alu1_data, alu2_data    ALU operands A and B
//   funct3, funct5, bit30   inst[14:12], inst[6:2], inst[30]
//   out_rd                  inst[11:7]
//   out_store               rs2 value (store data / branch compare)
//   out_pc                  PC of the held instruction
//   out_illegal             opcode class is not one this stage issues

module alu_issue_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  input  logic        fwd_we,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu1_data,
  output logic [31:0] alu2_data,
  output logic [2:0]  funct3,
  output logic [4:0]  funct5,
  output logic        bit30,
  output logic [4:0]  out_rd,
  output logic [31:0] out_store,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  logic        r_valid;
  logic [31:0] r_alu1;
  logic [31:0] r_alu2;
  logic [2:0]  r_funct3;
  logic [4:0]  r_funct5;
  logic        r_bit30;
  logic [4:0]  r_rd;
  logic [31:0] r_store;
  logic [31:0] r_pc;
  logic        r_illegal;

  logic [4:0]  w_opc;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_alu1;
  logic [31:0] w_alu2;
  logic        w_illegal;
  logic        w_capture;

  assign w_opc     = in_inst[6:2];
  assign w_rs1_idx = in_inst[19:15];
  assign w_rs2_idx = in_inst[24:20];

  // Instruction length bits are not checked here.
  logic w_unused_inst;
  assign w_unused_inst = ^in_inst[1:0];

`ifdef ALU_ISSUE_FWD_EN
  // x0 is never forwarded: a writeback to x0 must not mask the constant zero.
  assign w_rs1_val = (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == w_rs1_idx)) ? fwd_data : rs1_data;
  assign w_rs2_val = (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == w_rs2_idx)) ? fwd_data : rs2_data;
`else
  assign w_rs1_val = rs1_data;
  assign w_rs2_val = rs2_data;

  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_we, fwd_rd, fwd_data, w_rs1_idx, w_rs2_idx};
`endif

  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'b0};
  assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};

  always_comb begin
    w_alu1    = 32'd0;
    w_alu2    = 32'd0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_alu1 = w_rs1_val;
        w_alu2 = w_rs2_val;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        w_alu1 = w_rs1_val;
        w_alu2 = w_imm_i;
      end
      OPC_STORE: begin
        w_alu1 = w_rs1_val;
        w_alu2 = w_imm_s;
      end
      OPC_BRANCH: begin
        w_alu1 = in_pc;
        w_alu2 = w_imm_b;
      end
      OPC_JAL: begin
        w_alu1 = in_pc;
        w_alu2 = w_imm_j;
      end
      OPC_LUI: begin
        w_alu1 = 32'd0;
        w_alu2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_alu1 = in_pc;
        w_alu2 = w_imm_u;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Single slot, no skid: accept when empty or when the held entry leaves now.
  assign in_ready  = ~r_valid | out_ready;
  assign w_capture = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_alu1    <= 32'd0;
      r_alu2    <= 32'd0;
      r_funct3  <= 3'd0;
      r_funct5  <= 5'd0;
      r_bit30   <= 1'b0;
      r_rd      <= 5'd0;
      r_store   <= 32'd0;
      r_pc      <= RESET_PC;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_alu1    <= w_alu1;
      r_alu2    <= w_alu2;
      r_funct3  <= in_inst[14:12];
      r_funct5  <= w_opc;
      r_bit30   <= in_inst[30];
      r_rd      <= in_inst[11:7];
      r_store   <= w_rs2_val;
      r_pc      <= in_pc;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      // Data fields keep their last value; only the valid flag drops.
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign alu1_data   = r_alu1;
  assign alu2_data   = r_alu2;
  assign funct3      = r_funct3;
  assign funct5      = r_funct5;
  assign bit30       = r_bit30;
  assign out_rd      = r_rd;
  assign out_store   = r_store;
  assign out_pc      = r_pc;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and short random stimulus for alu_issue_stage. Expected issue
// records are computed from the instruction at capture time, queued, and
// compared when the execute side consumes the slot.

module tb_alu_issue_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu1_data;
  logic [31:0] alu2_data;
  logic [2:0]  funct3;
  logic [4:0]  funct5;
  logic        bit30;
  logic [4:0]  out_rd;
  logic [31:0] out_store;
  logic [31:0] out_pc;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu1_data(alu1_data), .alu2_data(alu2_data),
    .funct3(funct3), .funct5(funct5), .bit30(bit30),
    .out_rd(out_rd), .out_store(out_store), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] st;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [4:0]  f5;
    logic        b30;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  bit   m_valid = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] r1_in, input logic [31:0] r2_in,
                                      input logic fwe, input logic [4:0] frd,
                                      input logic [31:0] fdat);
    exp_t e;
    logic [31:0] r1, r2;
    logic signed [31:0] t;
    logic [31:0] ii, is, ib, iu, ij;
    r1 = r1_in;
    r2 = r2_in;
`ifdef ALU_ISSUE_FWD_EN
    if (fwe && frd != 5'd0 && frd == inst[19:15]) r1 = fdat;
    if (fwe && frd != 5'd0 && frd == inst[24:20]) r2 = fdat;
`else
    if (fwe && frd == 5'd31 && fdat == 32'd0) r1 = r1_in;
`endif
    t  = inst;                                   ii = 32'(t >>> 20);
    t  = {inst[31:25], inst[11:7], 20'd0};       is = 32'(t >>> 20);
    t  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0, 19'd0};
    ib = 32'(t >>> 19);
    t  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0, 11'd0};
    ij = 32'(t >>> 11);
    iu = inst & 32'hFFFF_F000;
    e.st  = r2;
    e.pc  = pc;
    e.f3  = inst[14:12];
    e.f5  = inst[6:2];
    e.b30 = inst[30];
    e.rd  = inst[11:7];
    e.ill = 1'b0;
    case (inst[6:2])
      5'b01100: begin e.a1 = r1; e.a2 = r2; end
      5'b00100: begin e.a1 = r1; e.a2 = ii; end
      5'b00000: begin e.a1 = r1; e.a2 = ii; end
      5'b11001: begin e.a1 = r1; e.a2 = ii; end
      5'b01000: begin e.a1 = r1; e.a2 = is; end
      5'b11000: begin e.a1 = pc; e.a2 = ib; end
      5'b11011: begin e.a1 = pc; e.a2 = ij; end
      5'b01101: begin e.a1 = 32'd0; e.a2 = iu; end
      5'b00101: begin e.a1 = pc; e.a2 = iu; end
      default:  begin e.a1 = 32'd0; e.a2 = 32'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock: handshake checks and scoreboard work at the falling edge,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    bit   cap, cons;
    @(negedge clk);
    if (!rst) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    end
    if (rst || flush) begin
      sb.delete();
      m_valid = 1'b0;
    end else begin
      cons = m_valid && out_ready;
      cap  = in_valid && (!m_valid || out_ready);
      if (cons) begin
        chk("sb_depth", sb.size(), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("alu1", alu1_data, e.a1);
          chk("alu2", alu2_data, e.a2);
          chk("store", out_store, e.st);
          chk("pc", out_pc, e.pc);
          chk("funct3", {29'd0, funct3}, {29'd0, e.f3});
          chk("funct5", {27'd0, funct5}, {27'd0, e.f5});
          chk("bit30", {31'd0, bit30}, {31'd0, e.b30});
          chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
          chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        end
      end
      if (cap) begin
        sb.push_back(ref_decode(in_inst, in_pc, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data));
        m_valid = 1'b1;
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_fwd;
    logic [4:0]  classes [10];
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0;
    fwd_we = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0; out_ready = 1'b1;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu1", alu1_data, 32'd0);
    chk("rst_alu2", alu2_data, 32'd0);
    chk("rst_store", out_store, 32'd0);
    chk("rst_f3", {29'd0, funct3}, 32'd0);
    chk("rst_f5", {27'd0, funct5}, 32'd0);
    chk("rst_b30", {31'd0, bit30}, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_ill", {31'd0, out_illegal}, 32'd0);
    chk("rst_pc", out_pc, TB_RESET_PC);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD x3,x1,x2
    offer(32'h002081B3, 32'h200, 32'd5, 32'd7);
    tick();
    chk("add_alu1", alu1_data, 32'd5);
    chk("add_alu2", alu2_data, 32'd7);
    chk("add_f5", {27'd0, funct5}, 32'h0C);
    chk("add_f3", {29'd0, funct3}, 32'd0);
    chk("add_b30", {31'd0, bit30}, 32'd0);
    chk("add_rd", {27'd0, out_rd}, 32'd3);

    // AUIPC then BEQ back to back
    offer(32'h12345097, 32'h100, 32'hDEAD0001, 32'hDEAD0002);
    tick();
    chk("auipc_alu1", alu1_data, 32'h100);
    chk("auipc_alu2", alu2_data, 32'h12345000);
    offer(32'hFE208CE3, 32'h104, 32'd11, 32'd22);
    tick();
    chk("beq_alu1", alu1_data, 32'h104);
    chk("beq_alu2", alu2_data, 32'hFFFF_FFF8);
    chk("beq_store", out_store, 32'd22);
    in_valid = 1'b0;
    tick();

    // Backpressure: addi x5,x1,-1 held while sw x2,-4(x1) waits
    offer(32'hFFF08293, 32'h300, 32'd10, 32'd0);
    tick();
    out_ready = 1'b0;
    offer(32'hFE20AE23, 32'h304, 32'd40, 32'h5555_AAAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_alu1", alu1_data, 32'd10);
      chk("stall_alu2", alu2_data, 32'hFFFF_FFFF);
      chk("stall_pc", out_pc, 32'h300);
    end
    out_ready = 1'b1;
    tick();
    chk("replace_valid", {31'd0, out_valid}, 32'd1);
    chk("sw_alu2", alu2_data, 32'hFFFF_FFFC);
    chk("sw_store", out_store, 32'h5555_AAAA);
    in_valid = 1'b0;
    tick();

    // Flush while a held instruction and a new one are both present
    out_ready = 1'b0;
    offer(32'hABCDE3B7, 32'h400, 32'd0, 32'd0);
    tick();
    chk("lui_alu2", alu2_data, 32'hABCDE000);
    offer(32'h0080006F, 32'h404, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_sb_empty", sb.size(), 32'd0);

    // Other classes: JAL, JALR, SUB, illegal
    offer(32'h8000006F, 32'h500, 32'd0, 32'd0);   tick();
    chk("jal_alu2", alu2_data, 32'hFFF0_0000);
    offer(32'h80008067, 32'h504, 32'd64, 32'd0);  tick();
    offer(32'h402081B3, 32'h508, 32'd9, 32'd4);   tick();
    chk("sub_b30", {31'd0, bit30}, 32'd1);
    offer(32'h1234567F, 32'h50C, 32'd1, 32'd2);   tick();
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_alu1", alu1_data, 32'd0);
    in_valid = 1'b0;
    tick();

    // Forwarding: addi x6,x5,0 with writeback to x5, then to x0
`ifdef ALU_ISSUE_FWD_EN
    exp_fwd = 32'd99;
`else
    exp_fwd = 32'd1;
`endif
    fwd_we = 1'b1; fwd_rd = 5'd5; fwd_data = 32'd99;
    offer(32'h00028313, 32'h600, 32'd1, 32'd0);   tick();
    chk("fwd_alu1", alu1_data, exp_fwd);
    fwd_rd = 5'd0;
    offer(32'h00028313, 32'h604, 32'd1, 32'd0);   tick();
    chk("fwd_x0_alu1", alu1_data, 32'd1);
    fwd_rd = 5'd2;
    offer(32'h002081B3, 32'h608, 32'd3, 32'd1);   tick();
    fwd_we = 1'b0; in_valid = 1'b0;
    tick();

    // Random mix with random backpressure and occasional flush
    classes = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                5'b11011, 5'b11001, 5'b01101, 5'b00101, 5'b11111};
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = {$urandom() >> 7, classes[$urandom_range(0, 9)], 2'b11};
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      rs1_data  = $urandom();
      rs2_data  = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      fwd_we    = $urandom_range(0, 1) == 1;
      fwd_rd    = 5'($urandom_range(0, 31));
      fwd_data  = $urandom();
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; fwd_we = 1'b0;
    for (int i = 0; i < 4 && m_valid; i++) tick();
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
